// File: rtl/cpu_multicycle.sv
// cpu_multicycle: parametrised multi-cycle core, FETCH -> EXEC -> [MEM] -> FETCH.
// Ports: CLK, RESET (async, active-low), PC, I_READ/I_BUSYWAIT/INSTRUCTION,
//   D_READ/D_WRITE/D_ADDR/D_WRITEDATA/D_READDATA/D_BUSYWAIT, RETIRE, ILLEGAL, HALTED.
module cpu_multicycle #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  parameter int PC_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [PC_W-1:0]   PC,
  output logic              I_READ,
  input  logic              I_BUSYWAIT,
  input  logic [31:0]       INSTRUCTION,
  output logic              D_READ,
  output logic              D_WRITE,
  output logic [DATA_W-1:0] D_ADDR,
  output logic [DATA_W-1:0] D_WRITEDATA,
  input  logic [DATA_W-1:0] D_READDATA,
  input  logic              D_BUSYWAIT,
  output logic              RETIRE,
  output logic              ILLEGAL,
  output logic              HALTED
);

  localparam int RI_W = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;
  localparam logic [7:0] OP_BNE   = 8'h0C;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  logic [1:0]        state_q, state_d;
  logic              run_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] rf_q [NREG];

  logic              we;
  logic [DATA_W-1:0] wd;
  logic              retire, illegal;

  logic [7:0]        op, rd_f, rs1_f, rs2_f;
  logic [DATA_W-1:0] rs1, rs2, imm, mem_addr;
  logic [PC_W-1:0]   pc_inc, br_tgt;
  logic              is_ld, is_st;
  logic              unused_ok;

  assign op    = ir_q[31:24];
  assign rd_f  = ir_q[23:16];
  assign rs1_f = ir_q[15:8];
  assign rs2_f = ir_q[7:0];
  assign unused_ok = ^{rd_f, rs1_f, rs2_f};

  assign rs1    = rf_q[rs1_f[RI_W-1:0]];
  assign rs2    = rf_q[rs2_f[RI_W-1:0]];
  assign imm    = DATA_W'($signed(rs2_f));
  assign pc_inc = pc_q + PC_W'(4);
  assign br_tgt = pc_inc + (PC_W'($signed(rd_f)) << 2);

  assign is_ld    = (op == OP_LWD) || (op == OP_LWI);
  assign is_st    = (op == OP_SWD) || (op == OP_SWI);
  assign mem_addr = ((op == OP_LWD) || (op == OP_SWD)) ? rs2 : imm;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    we      = 1'b0;
    wd      = '0;
    retire  = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        // run_q delays the first fetch request by one cycle after reset
        if (run_q && !I_BUSYWAIT) begin
          ir_d    = INSTRUCTION;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        retire  = 1'b1;
        case (op)
          OP_LOADI: begin we = 1'b1; wd = imm; end
          OP_MOV:   begin we = 1'b1; wd = rs2; end
          OP_ADD:   begin we = 1'b1; wd = rs1 + rs2; end
          OP_SUB:   begin we = 1'b1; wd = rs1 - rs2; end
          OP_AND:   begin we = 1'b1; wd = rs1 & rs2; end
          OP_OR:    begin we = 1'b1; wd = rs1 | rs2; end
          OP_J:     pc_d = br_tgt;
          OP_BEQ:   if (rs1 == rs2) pc_d = br_tgt;
          OP_BNE:   if (rs1 != rs2) pc_d = br_tgt;
          OP_LWD, OP_LWI, OP_SWD, OP_SWI: begin
            state_d = S_MEM;
            pc_d    = pc_q;
            retire  = 1'b0;
          end
          OP_HALT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
            retire  = 1'b0;
          end
          default:  illegal = 1'b1;
        endcase
      end
      S_MEM: begin
        if (!D_BUSYWAIT) begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
          retire  = 1'b1;
          we      = is_ld;
          wd      = D_READDATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      if (we) rf_q[rd_f[RI_W-1:0]] <= wd;
    end
  end

  assign PC          = pc_q;
  assign I_READ      = (state_q == S_FETCH) && run_q;
  assign D_READ      = (state_q == S_MEM) && is_ld;
  assign D_WRITE     = (state_q == S_MEM) && is_st;
  assign D_ADDR      = (state_q == S_MEM) ? mem_addr : '0;
  assign D_WRITEDATA = D_WRITE ? rs1 : '0;
  assign RETIRE      = retire;
  assign ILLEGAL     = illegal;
  assign HALTED      = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: table-driven bench for cpu_multicycle (8- and 16-bit instances
// run in lockstep), plus hand sequences for halt freeze and reset during MEM.
module tb_cpu_multicycle;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        I_BUSYWAIT = 1'b1;
  logic [31:0] INSTRUCTION = '0;
  logic [7:0]  D_READDATA = '0;
  logic [15:0] D_READDATA16;
  logic        D_BUSYWAIT = 1'b1;

  logic [31:0] PC, PC16;
  logic        I_READ, D_READ, D_WRITE, RETIRE, ILLEGAL, HALTED;
  logic        I_READ16, D_READ16, D_WRITE16, RETIRE16, ILLEGAL16, HALTED16;
  logic [7:0]  D_ADDR, D_WRITEDATA;
  logic [15:0] D_ADDR16, D_WRITEDATA16;

  assign D_READDATA16 = {8'h00, D_READDATA};

  cpu_multicycle dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .I_READ(I_READ),
    .I_BUSYWAIT(I_BUSYWAIT), .INSTRUCTION(INSTRUCTION),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR),
    .D_WRITEDATA(D_WRITEDATA), .D_READDATA(D_READDATA),
    .D_BUSYWAIT(D_BUSYWAIT), .RETIRE(RETIRE), .ILLEGAL(ILLEGAL),
    .HALTED(HALTED)
  );

  cpu_multicycle #(.DATA_W(16)) dut16 (
    .CLK(CLK), .RESET(RESET), .PC(PC16), .I_READ(I_READ16),
    .I_BUSYWAIT(I_BUSYWAIT), .INSTRUCTION(INSTRUCTION),
    .D_READ(D_READ16), .D_WRITE(D_WRITE16), .D_ADDR(D_ADDR16),
    .D_WRITEDATA(D_WRITEDATA16), .D_READDATA(D_READDATA16),
    .D_BUSYWAIT(D_BUSYWAIT), .RETIRE(RETIRE16), .ILLEGAL(ILLEGAL16),
    .HALTED(HALTED16)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // kinds: 0 alu/branch, 1 store, 2 load, 3 illegal, 4 halt
  typedef struct {
    logic [31:0] instr;
    int          iwait;
    int          dwait;
    logic [7:0]  rdata;
    int          kind;
    logic [31:0] pc;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [15:0] data16;
  } vec_t;

  vec_t tbl[29];

  logic        r_ret, r_ill, r_halt;
  int          r_wr, r_rd, r_lat;
  logic [7:0]  r_addr, r_data;
  logic [15:0] r_data16;
  logic [31:0] r_pc;

  task automatic run_instr(input logic [31:0] instr, input int iwait,
                           input int dwait, input logic [7:0] rdata);
    int t0, n, mc;
    r_ret = 0; r_ill = 0; r_halt = 0; r_wr = 0; r_rd = 0; r_lat = 0;
    r_addr = '0; r_data = '0; r_data16 = '0;
    n = 0;
    while (!I_READ && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("fetch_req", {31'd0, I_READ}, 32'd1);
    t0 = cyc;
    INSTRUCTION = instr;
    I_BUSYWAIT = 1'b1;
    for (int k = 0; k < iwait; k++) @(negedge CLK);
    I_BUSYWAIT = 1'b0;
    @(negedge CLK);
    I_BUSYWAIT = 1'b1;
    mc = 0;
    for (int k = 0; k < 40; k++) begin
      if (D_WRITE) begin
        r_wr++;
        r_addr = D_ADDR;
        r_data = D_WRITEDATA;
        r_data16 = D_WRITEDATA16;
      end
      if (D_READ) begin
        r_rd++;
        r_addr = D_ADDR;
      end
      if (D_READ || D_WRITE) begin
        D_BUSYWAIT = (mc < dwait);
        mc++;
      end
      D_READDATA = rdata;
      #1;
      if (RETIRE) begin
        r_ret = 1;
        r_ill = ILLEGAL;
        r_lat = cyc - t0 + 1;
        break;
      end
      if (HALTED) begin
        r_halt = 1;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    D_BUSYWAIT = 1'b1;
    r_pc = PC;
  endtask

  initial begin
    int errs;
    tbl[0]  = '{32'h00010005, 0, 0, 8'h00, 0, 32'h04, 8'h00, 8'h00, 16'h0000};
    tbl[1]  = '{32'h00020003, 0, 0, 8'h00, 0, 32'h08, 8'h00, 8'h00, 16'h0000};
    tbl[2]  = '{32'h03030102, 0, 0, 8'h00, 0, 32'h0C, 8'h00, 8'h00, 16'h0000};
    tbl[3]  = '{32'h0B000330, 0, 0, 8'h00, 1, 32'h10, 8'h30, 8'h02, 16'h0002};
    tbl[4]  = '{32'h0001007F, 0, 0, 8'h00, 0, 32'h14, 8'h00, 8'h00, 16'h0000};
    tbl[5]  = '{32'h00020001, 0, 0, 8'h00, 0, 32'h18, 8'h00, 8'h00, 16'h0000};
    tbl[6]  = '{32'h02030102, 0, 0, 8'h00, 0, 32'h1C, 8'h00, 8'h00, 16'h0000};
    tbl[7]  = '{32'h0B000331, 0, 0, 8'h00, 1, 32'h20, 8'h31, 8'h80, 16'h0080};
    tbl[8]  = '{32'h000100AB, 0, 0, 8'h00, 0, 32'h24, 8'h00, 8'h00, 16'h0000};
    tbl[9]  = '{32'h0B000120, 0, 3, 8'h00, 1, 32'h28, 8'h20, 8'hAB, 16'hFFAB};
    tbl[10] = '{32'h09040020, 0, 1, 8'hAB, 2, 32'h2C, 8'h20, 8'h00, 16'h0000};
    tbl[11] = '{32'h0A000402, 2, 0, 8'h00, 1, 32'h30, 8'h01, 8'hAB, 16'h00AB};
    tbl[12] = '{32'h04050103, 0, 0, 8'h00, 0, 32'h34, 8'h00, 8'h00, 16'h0000};
    tbl[13] = '{32'h05060502, 0, 0, 8'h00, 0, 32'h38, 8'h00, 8'h00, 16'h0000};
    tbl[14] = '{32'h01070006, 0, 0, 8'h00, 0, 32'h3C, 8'h00, 8'h00, 16'h0000};
    tbl[15] = '{32'h0B000740, 0, 0, 8'h00, 1, 32'h40, 8'h40, 8'h81, 16'h0081};
    tbl[16] = '{32'h00010007, 0, 0, 8'h00, 0, 32'h44, 8'h00, 8'h00, 16'h0000};
    tbl[17] = '{32'h00020007, 0, 0, 8'h00, 0, 32'h48, 8'h00, 8'h00, 16'h0000};
    tbl[18] = '{32'h07FE0102, 0, 0, 8'h00, 0, 32'h44, 8'h00, 8'h00, 16'h0000};
    tbl[19] = '{32'h0C070102, 0, 0, 8'h00, 0, 32'h48, 8'h00, 8'h00, 16'h0000};
    tbl[20] = '{32'h07100103, 0, 0, 8'h00, 0, 32'h4C, 8'h00, 8'h00, 16'h0000};
    tbl[21] = '{32'h0C020103, 0, 0, 8'h00, 0, 32'h58, 8'h00, 8'h00, 16'h0000};
    tbl[22] = '{32'h08000002, 0, 0, 8'h5A, 2, 32'h5C, 8'h07, 8'h00, 16'h0000};
    tbl[23] = '{32'h0B000000, 0, 0, 8'h00, 1, 32'h60, 8'h00, 8'h5A, 16'h005A};
    tbl[24] = '{32'h03050203, 0, 0, 8'h00, 0, 32'h64, 8'h00, 8'h00, 16'h0000};
    tbl[25] = '{32'h0B0005FF, 0, 0, 8'h00, 1, 32'h68, 8'hFF, 8'h87, 16'hFF87};
    tbl[26] = '{32'h3E000000, 0, 0, 8'h00, 3, 32'h6C, 8'h00, 8'h00, 16'h0000};
    tbl[27] = '{32'h06800000, 0, 0, 8'h00, 0, 32'hFFFFFE70, 8'h00, 8'h00, 16'h0000};
    tbl[28] = '{32'hFF000000, 0, 0, 8'h00, 4, 32'hFFFFFE70, 8'h00, 8'h00, 16'h0000};

    @(negedge CLK);
    @(negedge CLK);
    chk("rst_pc", PC, 32'h0);
    chk("rst_outs", {26'd0, I_READ, D_READ, D_WRITE, RETIRE, ILLEGAL, HALTED},
        32'h0);
    RESET = 1'b1;
    #1;
    chk("ird_at_release", {31'd0, I_READ}, 32'd0);
    @(negedge CLK);
    chk("ird_after_release", {31'd0, I_READ}, 32'd1);

    for (int i = 0; i < 29; i++) begin
      run_instr(tbl[i].instr, tbl[i].iwait, tbl[i].dwait, tbl[i].rdata);
      chk($sformatf("v%0d_retire", i), {31'd0, r_ret},
          {31'd0, tbl[i].kind != 4});
      chk($sformatf("v%0d_illegal", i), {31'd0, r_ill},
          {31'd0, tbl[i].kind == 3});
      chk($sformatf("v%0d_halted", i), {31'd0, r_halt},
          {31'd0, tbl[i].kind == 4});
      chk($sformatf("v%0d_pc", i), r_pc, tbl[i].pc);
      if (tbl[i].kind != 4)
        chk($sformatf("v%0d_latency", i), r_lat,
            2 + tbl[i].iwait +
            ((tbl[i].kind == 1 || tbl[i].kind == 2) ? 1 + tbl[i].dwait : 0));
      if (tbl[i].kind == 1) begin
        chk($sformatf("v%0d_wr_cycles", i), r_wr, tbl[i].dwait + 1);
        chk($sformatf("v%0d_wr_addr", i), {24'd0, r_addr},
            {24'd0, tbl[i].addr});
        chk($sformatf("v%0d_wr_data", i), {24'd0, r_data},
            {24'd0, tbl[i].data});
        chk($sformatf("v%0d_wr_data16", i), {16'd0, r_data16},
            {16'd0, tbl[i].data16});
      end else begin
        chk($sformatf("v%0d_no_write", i), r_wr, 0);
      end
      if (tbl[i].kind == 2) begin
        chk($sformatf("v%0d_rd_cycles", i), r_rd, tbl[i].dwait + 1);
        chk($sformatf("v%0d_rd_addr", i), {24'd0, r_addr},
            {24'd0, tbl[i].addr});
      end
    end

    errs = 0;
    INSTRUCTION = 32'h00010001;
    I_BUSYWAIT = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (PC !== 32'hFFFFFE70 || I_READ !== 1'b0 || HALTED !== 1'b1 ||
          RETIRE !== 1'b0)
        errs++;
    end
    chk("halt_freeze_errs", errs, 0);
    I_BUSYWAIT = 1'b1;

    RESET = 1'b0;
    @(negedge CLK);
    chk("halt_cleared", {31'd0, HALTED}, 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    run_instr(32'h00010055, 0, 0, 8'h00);
    chk("pre_rst_pc", r_pc, 32'h4);

    INSTRUCTION = 32'h0B000121;
    I_BUSYWAIT = 1'b0;
    @(negedge CLK);
    I_BUSYWAIT = 1'b1;
    D_BUSYWAIT = 1'b1;
    @(negedge CLK);
    chk("mem_wr_active", {31'd0, D_WRITE}, 32'd1);
    chk("mem_wr_data", {24'd0, D_WRITEDATA}, 32'h55);
    #2;
    RESET = 1'b0;
    #1;
    chk("rst_drops_wr", {31'd0, D_WRITE}, 32'd0);
    chk("rst_no_retire", {31'd0, RETIRE}, 32'd0);
    chk("rst_pc_mid", PC, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("post_rst_pc", PC, 32'h0);
    run_instr(32'h0B000122, 0, 0, 8'h00);
    chk("post_rst_r1", {24'd0, r_data}, 32'h0);
    chk("post_rst_addr", {24'd0, r_addr}, 32'h22);
    chk("post_rst_wr", r_wr, 1);
    chk("post_rst_pc2", r_pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
